// File: rtl/countdown_pkg.sv
// Shared types and constants for the seconds countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] MAX_SECS = 7'd99;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary (0..99) to two BCD digits.
module bin2bcd_99
  import countdown_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_t       tens,
  output bcd_t       ones
);

  always_comb begin
    tens = bcd_t'(bin / 7'd10);
    ones = bcd_t'(bin % 7'd10);
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Loadable, pausable seconds countdown driven by the timer's max_reached tick.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50,
  parameter int unsigned START_SECS    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       start,
  input  logic       pause,
  output bcd_t       tens_bcd,
  output bcd_t       ones_bcd,
  output logic       running,
  output logic       expired,
  output logic       timeout
);

  localparam int unsigned SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_LAST  = SW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    SECS_INIT = 7'(START_SECS);

  state_t        state, state_nxt;
  logic [6:0]    secs, secs_nxt;
  logic [SW-1:0] subcnt, subcnt_nxt;

  always_comb begin
    state_nxt  = state;
    secs_nxt   = secs;
    subcnt_nxt = subcnt;
    if (load) begin
      secs_nxt   = (load_value > MAX_SECS) ? MAX_SECS : load_value;
      subcnt_nxt = '0;
      state_nxt  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && secs != 7'd0) state_nxt = RUNNING;
        end
        RUNNING: begin
          // pause outranks tick, so a coincident tick is dropped
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick) begin
            if (subcnt == SUB_LAST) begin
              subcnt_nxt = '0;
              secs_nxt   = secs - 7'd1;
              if (secs == 7'd1) state_nxt = EXPIRED;
            end else begin
              subcnt_nxt = subcnt + SW'(1);
            end
          end
        end
        PAUSED: begin
          if (start) state_nxt = RUNNING;
        end
        EXPIRED: begin
          secs_nxt = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      secs    <= SECS_INIT;
      subcnt  <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      secs    <= secs_nxt;
      subcnt  <= subcnt_nxt;
      // flags are registered from the next state so they align with state
      running <= (state_nxt == RUNNING);
      expired <= (state_nxt == EXPIRED);
      timeout <= (state_nxt == EXPIRED) && (state != EXPIRED);
    end
  end

  bin2bcd_99 u_bcd (
    .bin  (secs),
    .tens (tens_bcd),
    .ones (ones_bcd)
  );

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed self-checking bench for countdown_sequencer (TICKS_PER_SEC=4, START_SECS=3).
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tens_bcd, ones_bcd;
  logic       running, expired, timeout;

  int unsigned checks = 0;
  int unsigned failures = 0;

  countdown_sequencer #(.TICKS_PER_SEC(4), .START_SECS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tens_bcd   (tens_bcd),
    .ones_bcd   (ones_bcd),
    .running    (running),
    .expired    (expired),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] digits,
                           input logic run, input logic exp_l, input logic to);
    check({tag, ".digits"}, {tens_bcd, ones_bcd}, digits);
    check({tag, ".flags"}, {5'd0, running, expired, timeout}, {5'd0, run, exp_l, to});
  endtask

  // inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step();
  endtask

  task automatic do_pause();
    pause = 1'b1; step();
  endtask

  task automatic do_load(input logic [6:0] v);
    load = 1'b1; load_value = v; step();
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick = 1'b1; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  initial begin
    #1;
    do_reset();
    check_out("reset", 8'h03, 1'b0, 1'b0, 1'b0);

    // 1: full countdown to expiry
    do_start();
    check_out("t1.start", 8'h03, 1'b1, 1'b0, 1'b0);
    ticks(3);
    check_out("t1.tick3", 8'h03, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_out("t1.tick4", 8'h02, 1'b1, 1'b0, 1'b0);
    ticks(4);
    check_out("t1.tick8", 8'h01, 1'b1, 1'b0, 1'b0);
    ticks(3);
    check_out("t1.tick11", 8'h01, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_out("t1.tick12", 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    check_out("t1.after", 8'h00, 1'b0, 1'b1, 1'b0);

    // 2: pause holds the partial second
    do_reset();
    do_start();
    ticks(6);
    check_out("t2.tick6", 8'h02, 1'b1, 1'b0, 1'b0);
    do_pause();
    check_out("t2.paused", 8'h02, 1'b0, 1'b0, 1'b0);
    ticks(5);
    check_out("t2.ptick", 8'h02, 1'b0, 1'b0, 1'b0);
    do_start();
    check_out("t2.resume", 8'h02, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_out("t2.rtick1", 8'h02, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_out("t2.rtick2", 8'h01, 1'b1, 1'b0, 1'b0);
    // pause with a coincident tick drops the tick
    pause = 1'b1; tick = 1'b1; step();
    ticks(1);
    do_start();
    ticks(3);
    check_out("t2.droptick", 8'h01, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check_out("t2.expire", 8'h00, 1'b0, 1'b1, 1'b1);

    // 3: load saturates at 99
    do_load(7'd120);
    check_out("t3.load", 8'h99, 1'b0, 1'b0, 1'b0);
    do_start();
    ticks(4);
    check_out("t3.tick4", 8'h98, 1'b1, 1'b0, 1'b0);

    // 4: load of 0 beats same-cycle start; start at zero is ignored
    load = 1'b1; load_value = 7'd0; start = 1'b1; step();
    check_out("t4.load0", 8'h00, 1'b0, 1'b0, 1'b0);
    do_start();
    check_out("t4.start0", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check_out("t4.idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 5: asynchronous reset while running
    do_reset();
    do_start();
    ticks(4);
    check_out("t5.pre", 8'h02, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("t5.async", 8'h03, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    step();
    do_start();
    ticks(4);
    check_out("t5.recount", 8'h02, 1'b1, 1'b0, 1'b0);

    // 6: expired ignores start/pause/tick; load exits
    ticks(8);
    check_out("t6.expire", 8'h00, 1'b0, 1'b1, 1'b1);
    do_start();
    check_out("t6.start", 8'h00, 1'b0, 1'b1, 1'b0);
    do_pause();
    check_out("t6.pause", 8'h00, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      tick = 1'b1; step();
      check_out("t6.tick", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    do_load(7'd5);
    check_out("t6.load5", 8'h05, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
